// File: rtl/fe_event_capture.sv
// Front-end event capture: timestamps PHY data strobes and status changes and
// writes DATA/STAT/TIME/DROP records to the capture FIFO. Optional: FE_CAPTURE_DROP_COUNT_EN.
module fe_event_capture #(
  parameter int pDATA_WIDTH            = 8,
  parameter int pSTATUS_WIDTH          = 5,
  parameter int pTIMESTAMP_FULL_WIDTH  = 16,
  parameter int pTIMESTAMP_SHORT_WIDTH = 3,
  parameter int pQUEUE_DEPTH           = 4,
  parameter int pLEN_WIDTH             = 16
) (
  input  logic                             fe_clk,
  input  logic                             reset_n,
  input  logic [pDATA_WIDTH-1:0]           fe_data,
  input  logic                             fe_valid,
  input  logic [pSTATUS_WIDTH-1:0]         fe_status,
  input  logic                             I_timestamps_disable,
  input  logic                             I_arm,
  input  logic [pLEN_WIDTH-1:0]            I_capture_len,
  input  logic                             I_capture_enable,
  input  logic                             I_fifo_full,
  output logic [1:0]                       O_command,
  output logic [pTIMESTAMP_FULL_WIDTH-1:0] O_time,
  output logic [pDATA_WIDTH-1:0]           O_data,
  output logic [pSTATUS_WIDTH-1:0]         O_status,
  output logic                             O_data_wr,
  output logic [pDATA_WIDTH-1:0]           O_pm_data,
  output logic                             O_pm_wr,
  output logic                             O_capturing,
  output logic [15:0]                      O_drop_count,
  output logic [1:0]                       O_fsm_state
);

  localparam int PW = $clog2(pQUEUE_DEPTH);
  localparam logic [pTIMESTAMP_FULL_WIDTH-1:0] TMAX = '1;
  localparam logic [pTIMESTAMP_FULL_WIDTH-1:0] SHORT_LIM =
    pTIMESTAMP_FULL_WIDTH'(1) << pTIMESTAMP_SHORT_WIDTH;
  localparam logic [PW:0] Q_FULL = (PW+1)'(pQUEUE_DEPTH);

  localparam logic [1:0] CMD_DATA = 2'd0;
  localparam logic [1:0] CMD_STAT = 2'd1;
  localparam logic [1:0] CMD_TIME = 2'd2;
  localparam logic [1:0] CMD_DROP = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_EVT} state_t;

  typedef struct packed {
    logic                             is_time;
    logic                             valid;
    logic [pDATA_WIDTH-1:0]           data;
    logic [pSTATUS_WIDTH-1:0]         status;
    logic [pTIMESTAMP_FULL_WIDTH-1:0] gap;
  } entry_t;

  logic [pDATA_WIDTH-1:0]           data_r;
  logic                             valid_r;
  logic [pSTATUS_WIDTH-1:0]         status_r;
  logic [pSTATUS_WIDTH-1:0]         status_prev;
  logic                             arm_r;
  logic [pTIMESTAMP_FULL_WIDTH-1:0] gap_cnt;
  logic                             gap_run;
  entry_t                           q_mem [pQUEUE_DEPTH];
  logic [PW-1:0]                    wr_ptr;
  logic [PW-1:0]                    rd_ptr;
  logic [PW:0]                      q_cnt;
  logic [pLEN_WIDTH-1:0]            cap_cnt;
  logic [pLEN_WIDTH-1:0]            cnt_n;
  logic [pTIMESTAMP_FULL_WIDTH-1:0] pend_cnt;
  logic [15:0]                      drop_cnt;
  state_t                           state;
  state_t                           state_n;

  logic                             fe_event;
  logic                             arm_rise;
  logic                             flush;
  logic                             q_full;
  logic                             q_empty;
  logic [pTIMESTAMP_FULL_WIDTH-1:0] gap_inc;
  logic                             roll;
  logic                             ev_push;
  logic                             time_push;
  logic                             push;
  entry_t                           push_entry;
  entry_t                           head;

  logic                             wr_en;
  logic                             pop;
  logic [1:0]                       cmd_n;
  logic [pTIMESTAMP_FULL_WIDTH-1:0] time_n;
  logic [pDATA_WIDTH-1:0]           data_n;
  logic [pSTATUS_WIDTH-1:0]         status_n;

  // Stage 0: PHY pins registered once; the pattern matcher taps this stage.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r      <= '0;
      valid_r     <= 1'b0;
      status_r    <= '0;
      status_prev <= '0;
      arm_r       <= 1'b0;
    end else begin
      data_r      <= fe_data;
      valid_r     <= fe_valid;
      status_r    <= fe_status;
      status_prev <= status_r;
      arm_r       <= I_arm;
    end
  end

  assign fe_event = valid_r | (status_r != status_prev);
  assign arm_rise = I_arm & ~arm_r;
  assign flush    = arm_rise | ~O_capturing;
  assign q_full   = (q_cnt == Q_FULL);
  assign q_empty  = (q_cnt == '0);
  assign head     = q_mem[rd_ptr];

  // gap_cnt never exceeds TMAX-1, so gap_inc cannot wrap.
  assign gap_inc   = gap_cnt + 1'b1;
  assign roll      = gap_run & ~I_timestamps_disable & (gap_inc == TMAX);
  assign ev_push   = fe_event & ~flush & ~q_full;
  assign time_push = roll & ~fe_event & ~flush & ~q_full;
  assign push      = ev_push | time_push;

  always_comb begin
    push_entry         = '0;
    push_entry.is_time = time_push;
    push_entry.valid   = valid_r;
    push_entry.data    = data_r;
    push_entry.status  = status_r;
    push_entry.gap     = (I_timestamps_disable || !gap_run) ? '0 : gap_inc;
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt <= '0;
      gap_run <= 1'b0;
    end else if (arm_rise || !I_capture_enable || I_timestamps_disable) begin
      gap_cnt <= '0;
      gap_run <= 1'b0;
    end else if (push) begin
      gap_cnt <= '0;
      gap_run <= 1'b1;
    end else if (gap_run && gap_inc != TMAX) begin
      gap_cnt <= gap_inc;
    end
  end

  always_ff @(posedge fe_clk) begin
    if (push) q_mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      q_cnt <= q_cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  // Record emitter. S_EVT means the TIME prefix of the head event is out.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n  = state;
    wr_en    = 1'b0;
    pop      = 1'b0;
    cmd_n    = CMD_DATA;
    time_n   = '0;
    data_n   = '0;
    status_n = '0;
    if (flush) begin
      state_n = S_IDLE;
    end else if (!I_fifo_full) begin
      if (state == S_EVT) begin
        wr_en    = 1'b1;
        pop      = 1'b1;
        cmd_n    = head.valid ? CMD_DATA : CMD_STAT;
        data_n   = head.data;
        status_n = head.status;
        state_n  = S_EMIT;
      end else if (pend_cnt != '0) begin
        wr_en   = 1'b1;
        cmd_n   = CMD_DROP;
        time_n  = pend_cnt;
        state_n = S_EMIT;
      end else if (!q_empty) begin
        wr_en   = 1'b1;
        state_n = S_EMIT;
        if (head.is_time) begin
          pop    = 1'b1;
          cmd_n  = CMD_TIME;
          time_n = head.gap;
        end else if (!I_timestamps_disable && head.gap >= SHORT_LIM) begin
          cmd_n   = CMD_TIME;
          time_n  = head.gap;
          state_n = S_EVT;
        end else begin
          pop      = 1'b1;
          cmd_n    = head.valid ? CMD_DATA : CMD_STAT;
          time_n   = I_timestamps_disable ? '0 : head.gap;
          data_n   = head.data;
          status_n = head.status;
        end
      end else begin
        state_n = S_IDLE;
      end
    end
  end

  assign cnt_n = arm_rise ? '0 : (wr_en ? cap_cnt + 1'b1 : cap_cnt);

  // O_capturing tracks the count it will see next cycle so writes stop exactly at the length.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_cnt     <= '0;
      O_capturing <= 1'b0;
    end else begin
      cap_cnt     <= cnt_n;
      O_capturing <= I_capture_enable && (cnt_n < I_capture_len);
    end
  end

`ifdef FE_CAPTURE_DROP_COUNT_EN
  logic                             ev_drop;
  logic [pTIMESTAMP_FULL_WIDTH-1:0] pend_base;

  assign ev_drop   = fe_event & ~flush & q_full;
  assign pend_base = (wr_en && cmd_n == CMD_DROP) ? '0 : pend_cnt;

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
      pend_cnt <= '0;
    end else if (arm_rise) begin
      drop_cnt <= '0;
      pend_cnt <= '0;
    end else begin
      if (ev_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      pend_cnt <= (ev_drop && pend_base != TMAX) ? pend_base + 1'b1 : pend_base;
    end
  end
`else
  assign drop_cnt = '0;
  assign pend_cnt = '0;
`endif

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      O_command <= '0;
      O_time    <= '0;
      O_data    <= '0;
      O_status  <= '0;
      O_data_wr <= 1'b0;
      O_pm_data <= '0;
      O_pm_wr   <= 1'b0;
    end else begin
      O_command <= cmd_n;
      O_time    <= time_n;
      O_data    <= data_n;
      O_status  <= status_n;
      O_data_wr <= wr_en;
      O_pm_data <= fe_data;
      O_pm_wr   <= fe_valid;
    end
  end

  assign O_drop_count = drop_cnt;
  assign O_fsm_state  = state;

endmodule

// File: tb/tb_fe_event_capture.sv
// Directed bench for fe_event_capture: vector table for the inline/long-gap
// record stream plus hand sequences for backpressure, length, rollover and reset.
module tb_fe_event_capture;

  localparam int DW = 8;
  localparam int SW = 5;
  localparam int TW = 16;
  localparam int LW = 16;
  localparam int RW = 2 + TW + DW + SW;

  logic          fe_clk;
  logic          reset_n;
  logic [DW-1:0] fe_data;
  logic          fe_valid;
  logic [SW-1:0] fe_status;
  logic          I_timestamps_disable;
  logic          I_arm;
  logic [LW-1:0] I_capture_len;
  logic          I_capture_enable;
  logic          I_fifo_full;
  logic [1:0]    O_command;
  logic [TW-1:0] O_time;
  logic [DW-1:0] O_data;
  logic [SW-1:0] O_status;
  logic          O_data_wr;
  logic [DW-1:0] O_pm_data;
  logic          O_pm_wr;
  logic          O_capturing;
  logic [15:0]   O_drop_count;
  logic [1:0]    dbg_state;

  fe_event_capture dut (
    .fe_clk               (fe_clk),
    .reset_n              (reset_n),
    .fe_data              (fe_data),
    .fe_valid             (fe_valid),
    .fe_status            (fe_status),
    .I_timestamps_disable (I_timestamps_disable),
    .I_arm                (I_arm),
    .I_capture_len        (I_capture_len),
    .I_capture_enable     (I_capture_enable),
    .I_fifo_full          (I_fifo_full),
    .O_command            (O_command),
    .O_time               (O_time),
    .O_data               (O_data),
    .O_status             (O_status),
    .O_data_wr            (O_data_wr),
    .O_pm_data            (O_pm_data),
    .O_pm_wr              (O_pm_wr),
    .O_capturing          (O_capturing),
    .O_drop_count         (O_drop_count),
    .O_fsm_state          (dbg_state)
  );

  // clock / cycle counter
  int unsigned cyc;
  initial fe_clk = 1'b0;
  always #5 fe_clk = ~fe_clk;
  initial cyc = 0;
  always @(posedge fe_clk) cyc <= cyc + 1;

  // scoreboard
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];
  int unsigned   got_cyc_q[$];
  int            errors = 0;
  int            checks = 0;

  always @(negedge fe_clk) begin
    if (reset_n && O_data_wr) begin
      got_q.push_back({O_command, O_time, O_data, O_status});
      got_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_rec(input logic [1:0] cmd, input logic [TW-1:0] t,
                            input logic [DW-1:0] d, input logic [SW-1:0] s);
    exp_q.push_back({cmd, t, d, s});
  endtask

  // DATA event with a hand-computed gap; long gaps come out as TIME + DATA(0).
  task automatic expect_data(input logic [DW-1:0] d, input logic [TW-1:0] gap);
    if (gap >= 16'd8) begin
      expect_rec(2'd2, gap, '0, '0);
      expect_rec(2'd0, '0, d, '0);
    end else begin
      expect_rec(2'd0, gap, d, '0);
    end
  endtask

  task automatic compare_records(input string name);
    int n;
    check($sformatf("%s count", name), 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s rec%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    got_cyc_q.delete();
    exp_q.delete();
  endtask

  // drivers
  task automatic idle(input int unsigned n);
    repeat (n) @(negedge fe_clk);
  endtask

  task automatic strobe(input logic [DW-1:0] d);
    fe_valid = 1'b1;
    fe_data  = d;
    @(negedge fe_clk);
    fe_valid = 1'b0;
    fe_data  = '0;
  endtask

  task automatic rearm();
    I_arm = 1'b1;
    @(negedge fe_clk);
    I_arm = 1'b0;
    idle(2);
    got_q.delete();
    got_cyc_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    int unsigned   wait_cyc;
    logic [DW-1:0] data;
    logic [TW-1:0] exp_gap;
  } vec_t;

  vec_t        vecs[7];
  int unsigned t0;

  initial begin
    vecs[0] = '{0, 8'hA1, 16'd0};
    vecs[1] = '{2, 8'hA2, 16'd2};
    vecs[2] = '{2, 8'hA3, 16'd2};
    vecs[3] = '{9, 8'hA4, 16'd9};
    vecs[4] = '{1, 8'hA5, 16'd1};
    vecs[5] = '{8, 8'hA6, 16'd8};
    vecs[6] = '{7, 8'hA7, 16'd7};

    reset_n              = 1'b0;
    fe_data              = '0;
    fe_valid             = 1'b0;
    fe_status            = '0;
    I_timestamps_disable = 1'b0;
    I_arm                = 1'b0;
    I_capture_len        = 16'hFFFF;
    I_capture_enable     = 1'b1;
    I_fifo_full          = 1'b0;
    idle(3);
    check("rst command", 32'(O_command), 0);
    check("rst data_wr", 32'(O_data_wr), 0);
    check("rst capturing", 32'(O_capturing), 0);
    check("rst drop_count", 32'(O_drop_count), 0);
    check("rst pm_wr", 32'(O_pm_wr), 0);
    reset_n = 1'b1;
    idle(3);

    // inline and long gaps from the vector table
    rearm();
    t0 = 0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) idle(vecs[i].wait_cyc - 1);
      if (i == 0) t0 = cyc;
      strobe(vecs[i].data);
      check($sformatf("pm_wr v%0d", i), 32'(O_pm_wr), 1);
      check($sformatf("pm_data v%0d", i), 32'(O_pm_data), 32'(vecs[i].data));
      expect_data(vecs[i].data, vecs[i].exp_gap);
    end
    idle(12);
    check("first write latency", (got_cyc_q.size() > 0) ? got_cyc_q[0] - t0 : 0, 3);
    compare_records("vectors");

    // status change 20 cycles after an event
    rearm();
    strobe(8'h5A);
    expect_rec(2'd0, 16'd0, 8'h5A, 5'h00);
    idle(19);
    fe_status = 5'h05;
    expect_rec(2'd2, 16'd20, 8'h00, 5'h00);
    expect_rec(2'd1, 16'd0, 8'h00, 5'h05);
    idle(10);
    compare_records("status");
    fe_status = 5'h00;
    idle(10);

    // timestamps disabled across a long gap
    I_timestamps_disable = 1'b1;
    rearm();
    strobe(8'hB1);
    idle(99);
    strobe(8'hB2);
    idle(8);
    expect_rec(2'd0, 16'd0, 8'hB1, 5'h00);
    expect_rec(2'd0, 16'd0, 8'hB2, 5'h00);
    compare_records("ts_disable");
    I_timestamps_disable = 1'b0;

    // FIFO backpressure overflows the event queue
    rearm();
    I_fifo_full = 1'b1;
    for (int i = 0; i < 8; i++) strobe(8'hC0 + 8'(i));
    idle(2);
    I_fifo_full = 1'b0;
    idle(12);
`ifdef FE_CAPTURE_DROP_COUNT_EN
    expect_rec(2'd3, 16'd4, 8'h00, 5'h00);
    check("drop_count", 32'(O_drop_count), 4);
`else
    check("drop_count", 32'(O_drop_count), 0);
`endif
    expect_rec(2'd0, 16'd0, 8'hC0, 5'h00);
    for (int i = 1; i < 4; i++) expect_rec(2'd0, 16'd1, 8'hC0 + 8'(i), 5'h00);
    compare_records("backpressure");

    // capture length limit then re-arm
    I_capture_len = 16'd5;
    rearm();
    for (int i = 0; i < 10; i++) strobe(8'hD0 + 8'(i));
    idle(6);
    expect_rec(2'd0, 16'd0, 8'hD0, 5'h00);
    for (int i = 1; i < 5; i++) expect_rec(2'd0, 16'd1, 8'hD0 + 8'(i), 5'h00);
    compare_records("length");
    check("capturing after len", 32'(O_capturing), 0);
    rearm();
    check("capturing after arm", 32'(O_capturing), 1);
    strobe(8'hEE);
    idle(5);
    expect_rec(2'd0, 16'd0, 8'hEE, 5'h00);
    compare_records("rearm");
    I_capture_len = 16'hFFFF;
    rearm();

    // pattern-matcher tap with capture disabled
    I_capture_enable = 1'b0;
    idle(2);
    strobe(8'h3C);
    check("pm_wr no capture", 32'(O_pm_wr), 1);
    check("pm_data no capture", 32'(O_pm_data), 32'h3C);
    idle(6);
    check("no records when disabled", 32'(got_q.size()), 0);
    I_capture_enable = 1'b1;
    idle(2);
    rearm();

    // full-width rollover
    strobe(8'h77);
    expect_rec(2'd0, 16'd0, 8'h77, 5'h00);
    expect_rec(2'd2, 16'hFFFF, 8'h00, 5'h00);
    idle(65545);
    compare_records("rollover");

    // asynchronous reset in the middle of a burst
    for (int i = 0; i < 4; i++) strobe(8'h90 + 8'(i));
    #2 reset_n = 1'b0;
    #1;
    check("mid rst data_wr", 32'(O_data_wr), 0);
    check("mid rst command", 32'(O_command), 0);
    check("mid rst time", 32'(O_time), 0);
    check("mid rst data", 32'(O_data), 0);
    check("mid rst status", 32'(O_status), 0);
    check("mid rst pm", {O_pm_wr, O_pm_data}, 0);
    check("mid rst capturing", 32'(O_capturing), 0);
    check("mid rst drop_count", 32'(O_drop_count), 0);
    idle(2);
    reset_n = 1'b1;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
